// File: rtl/pb_arbiter_if.sv
// Button/result bundle between the push-button front end and the game logic.
// The arbiter takes the slave side; the game controller (or a bench) takes master.
interface pb_arbiter_if #(
  parameter int N_PLAYERS = 2,
  parameter int ID_W      = 1
);
  logic [N_PLAYERS-1:0] pb;
  logic                 clr;
  logic                 push;
  logic                 tie;
  logic [ID_W-1:0]      winner;
  logic [N_PLAYERS-1:0] tie_mask;
  logic [N_PLAYERS-1:0] foul;

  modport master (
    output pb, clr,
    input  push, tie, winner, tie_mask, foul
  );

  modport slave (
    input  pb, clr,
    output push, tie, winner, tie_mask, foul
  );
endinterface

// File: rtl/pb_arbiter.sv
// First-press arbiter for N push-buttons with tie detection and release-before-rearm.
// Optional sticky late-press flags are built only when PB_ARB_FOUL_EN is defined.
module pb_arbiter #(
  parameter int N_PLAYERS = 2,
  parameter int ID_W      = 1
) (
  input  logic          clk,
  input  logic          rst,
  pb_arbiter_if.slave   arb
);

  typedef enum logic [1:0] {WAIT_REL, ARMED, HELD} state_t;

  state_t               state, state_nxt;
  logic [N_PLAYERS-1:0] s1, s2, p;
  logic [N_PLAYERS-1:0] rise;
  logic [ID_W-1:0]      low_idx;
  logic                 multi;
  logic                 load, clear;

  logic                 push_q, tie_q;
  logic [ID_W-1:0]      winner_q;
  logic [N_PLAYERS-1:0] mask_q;

  // pb is asynchronous to clk, so only s2 onward is trusted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      p  <= '0;
    end else begin
      s1 <= arb.pb;
      s2 <= s1;
      p  <= s2;
    end
  end

  assign rise  = s2 & ~p;
  assign multi = |(rise & (rise - N_PLAYERS'(1)));

  always_comb begin
    low_idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (rise[i]) low_idx = ID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_REL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clear     = 1'b0;
    case (state)
      WAIT_REL: begin
        if (s2 == '0) state_nxt = ARMED;
      end
      ARMED: begin
        if (arb.clr) begin
          state_nxt = WAIT_REL;
        end else if (rise != '0) begin
          state_nxt = HELD;
          load      = 1'b1;
        end
      end
      HELD: begin
        if (arb.clr) begin
          state_nxt = WAIT_REL;
          clear     = 1'b1;
        end
      end
      default: state_nxt = WAIT_REL;
    endcase
  end

  // Result registers: loaded once per round, zeroed when the controller clears.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      push_q   <= 1'b0;
      tie_q    <= 1'b0;
      winner_q <= '0;
      mask_q   <= '0;
    end else if (load) begin
      push_q   <= 1'b1;
      tie_q    <= multi;
      winner_q <= low_idx;
      mask_q   <= rise;
    end
  end

  assign arb.push     = push_q;
  assign arb.tie      = tie_q;
  assign arb.winner   = winner_q;
  assign arb.tie_mask = mask_q;

`ifdef PB_ARB_FOUL_EN
  logic [N_PLAYERS-1:0] foul_q;

  // Any fresh press while a result is held is a foul, including re-presses by winners.
  always_ff @(posedge clk) begin
    if (rst || clear) foul_q <= '0;
    else if (state == HELD) foul_q <= foul_q | rise;
  end

  assign arb.foul = foul_q;
`else
  assign arb.foul = '0;
`endif

endmodule

// File: tb/tb_pb_arbiter.sv
// Scoreboard bench for pb_arbiter (N_PLAYERS=4, ID_W=2); follows PB_ARB_FOUL_EN
// so foul expectations match the build.
module tb_pb_arbiter;

  localparam int N = 4;
  localparam int W = 2;

`ifdef PB_ARB_FOUL_EN
  localparam bit FOUL_ON = 1'b1;
`else
  localparam bit FOUL_ON = 1'b0;
`endif

  typedef struct packed {
    logic         push;
    logic         tie;
    logic [W-1:0] winner;
    logic [N-1:0] mask;
    logic [N-1:0] foul;
  } exp_t;

  logic   clk;
  logic   rst;
  exp_t   sbq[$];
  string  tagq[$];
  int     checkCount = 0;
  int     passCount  = 0;

  pb_arbiter_if #(.N_PLAYERS(N), .ID_W(W)) bus ();

  pb_arbiter #(.N_PLAYERS(N), .ID_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] pbVal, input logic c);
    rst    = r;
    bus.pb = pbVal;
    bus.clr = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    else
      passCount++;
  endtask

  task automatic expectState(input string tag, input logic ps, input logic t,
                             input logic [W-1:0] w, input logic [N-1:0] m,
                             input logic [N-1:0] f);
    exp_t e;
    e.push = ps; e.tie = t; e.winner = w; e.mask = m; e.foul = f;
    sbq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic compareState();
    exp_t  e;
    string tag;
    if (sbq.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e   = sbq.pop_front();
    tag = tagq.pop_front();
    checkOutput({tag, ".push"},     32'(bus.push),     32'(e.push));
    checkOutput({tag, ".tie"},      32'(bus.tie),      32'(e.tie));
    checkOutput({tag, ".winner"},   32'(bus.winner),   32'(e.winner));
    checkOutput({tag, ".tie_mask"}, 32'(bus.tie_mask), 32'(e.mask));
    checkOutput({tag, ".foul"},     32'(bus.foul),     32'(e.foul));
  endtask

  task automatic waitPush(input int budget);
    for (int i = 0; i < budget && bus.push !== 1'b1; i++) tick(1);
  endtask

  initial begin
    applyStimulus(1'b1, 4'b0000, 1'b0);
    expectState("reset", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(2);
    compareState();

    // Press lands on the first edge after reset; result appears after the third.
    applyStimulus(1'b0, 4'b0100, 1'b0);
    expectState("single_pre", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(2);
    compareState();
    expectState("single", 1'b1, 1'b0, 2'd2, 4'b0100, 4'b0000);
    tick(1);
    compareState();

    applyStimulus(1'b0, 4'b0000, 1'b1);
    expectState("clr1", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(1);
    compareState();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(4);

    applyStimulus(1'b0, 4'b1010, 1'b0);
    expectState("tie", 1'b1, 1'b1, 2'd1, 4'b1010, 4'b0000);
    tick(3);
    compareState();

    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick(1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(4);

    applyStimulus(1'b0, 4'b1000, 1'b0);
    tick(1);
    applyStimulus(1'b0, 4'b1001, 1'b0);
    expectState("skew", 1'b1, 1'b0, 2'd3, 4'b1000, 4'b0000);
    tick(2);
    compareState();

    // Clear while pb[3] is still down: stays disarmed until every button is up.
    applyStimulus(1'b0, 4'b1000, 1'b1);
    expectState("clr_held", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(1);
    compareState();
    applyStimulus(1'b0, 4'b1010, 1'b0);
    expectState("held_blocks", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(6);
    compareState();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(4);
    applyStimulus(1'b0, 4'b0010, 1'b0);
    expectState("rearm_win", 1'b1, 1'b0, 2'd1, 4'b0010, 4'b0000);
    waitPush(10);
    compareState();

    // Winner releases and re-presses together with pb[3] while the result is held.
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(3);
    applyStimulus(1'b0, 4'b1010, 1'b0);
    expectState("foul", 1'b1, 1'b0, 2'd1, 4'b0010, FOUL_ON ? 4'b1010 : 4'b0000);
    tick(3);
    compareState();
    applyStimulus(1'b0, 4'b0000, 1'b1);
    expectState("foul_clr", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(1);
    compareState();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(4);

    applyStimulus(1'b0, 4'b0100, 1'b0);
    expectState("stuck_first", 1'b1, 1'b0, 2'd2, 4'b0100, 4'b0000);
    waitPush(10);
    compareState();
    applyStimulus(1'b0, 4'b0100, 1'b1);
    tick(1);
    applyStimulus(1'b0, 4'b0101, 1'b0);
    expectState("stuck_blocks", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(6);
    compareState();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(4);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    expectState("stuck_win0", 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000);
    waitPush(10);
    compareState();

    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(3);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    expectState("refoul", 1'b1, 1'b0, 2'd0, 4'b0001, FOUL_ON ? 4'b0001 : 4'b0000);
    tick(3);
    compareState();

    // Reset mid-press, with clr also high, wipes everything including foul.
    applyStimulus(1'b1, 4'b0001, 1'b1);
    expectState("rst_mid", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(1);
    compareState();

    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(1);
    applyStimulus(1'b0, 4'b1100, 1'b0);
    expectState("post_rst_pre", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(2);
    compareState();
    expectState("post_rst_tie", 1'b1, 1'b1, 2'd2, 4'b1100, 4'b0000);
    tick(1);
    compareState();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pb_arbiter.md
# pb_arbiter

Parametrised, clocked successor to the two-button push logic in the tug-of-war game. It arbitrates N player push-buttons and latches the first new press, flagging a tie when presses land in the same cycle. It synchronises each raw button input and detects press edges, then holds the result until the game controller clears it. It also requires all buttons to be released before re-arming. It sits between the debounced button inputs and the game-state/scoring logic.

## Interface
- N_PLAYERS, 2, number of push-button channels (2..16)
- ID_W, 1, width of winner index; must satisfy 2^ID_W >= N_PLAYERS
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- pb  in  N_PLAYERS  raw button levels, asynchronous to clk, 1 = pressed
- clr  in  1  synchronous clear of latched result, sampled every edge
- push  out  1  result latched (single winner or tie)
- tie  out  1  latched result is a tie (valid when push=1)
- winner  out  ID_W  index of winning player; on tie, lowest tied index
- tie_mask  out  N_PLAYERS  one-hot winner, or all players pressing in the tie cycle
- foul  out  N_PLAYERS  sticky late-press flags (see Configuration)

## Operation
- Each pb bit passes through a 2-flop synchroniser (s1, s2), then a previous-value register p. rise = s2 & ~p.
- States: WAIT_REL, ARMED, HELD.
- WAIT_REL: outputs push/tie/winner/tie_mask held at 0. Go to ARMED when s2 == 0 (all released).
- ARMED: if clr=1, go to WAIT_REL and discard rise. Else if rise != 0, go to HELD and register the result:
  - push=1.
  - tie_mask=rise.
  - tie=1 iff popcount(rise) >= 2.
  - winner = lowest set index of rise.
- Presses already held on entry to ARMED produce no rise; they never win.
- HELD: outputs frozen; further presses ignored (apart from foul). clr=1 returns to WAIT_REL and zeroes push/tie/winner/tie_mask on the same edge.
- clr in WAIT_REL has no effect.
- rst=1 (any state, including mid-press): state WAIT_REL. s1, s2, p, and all outputs, including foul, go to 0. rst overrides clr.

## Timing
- Press latency: first clk edge sampling pb high = edge k; s2=1 at k+1; push/tie/winner/tie_mask valid after edge k+2.
- A pb pulse must be high across at least one rising edge with setup met; shorter pulses may be missed.
- Two presses tie only if they reach s2 on the same edge. One-cycle skew gives a single winner, the earlier one.
- clr to outputs zero: 1 edge. Re-arm: the first edge where s2 == 0 moves WAIT_REL to ARMED. A press can win 1 edge later at the earliest.
- After rst deassert with all buttons released: ARMED after 1 edge.
- Outputs are registered; no combinational path from pb or clr to outputs.

## Configuration
- PB_ARB_FOUL_EN defined:
  - In HELD, any rise bit sets the matching foul bit on the next edge.
  - foul is sticky and is cleared to 0 by rst or by clr accepted in HELD.
  - Presses by players already set in tie_mask still count as fouls (re-press after release).
- PB_ARB_FOUL_EN undefined: foul is tied to 0 and no foul logic is built; all other behaviour is identical.

## Test plan
All scenarios use N_PLAYERS=4, ID_W=2.
- Reset then single press: rst 1 for 2 edges, then pb=4'b0100 held → push=1, tie=0, winner=2, tie_mask=4'b0100 after the 3rd sampling edge. All outputs are 0 before that.
- Tie: pb=4'b1010 asserted on the same cycle → push=1, tie=1, winner=1, tie_mask=4'b1010.
- Skewed press: pb[3] rises, pb[0] rises one cycle later → winner=3, tie=0, tie_mask=4'b1000.
- Clear with a button held: in HELD, pulse clr with pb[3] still high → outputs 0 next edge; state stays WAIT_REL until pb=0. A new pb[1] press then wins with winner=1.
- Stuck button: pb[2] held through clr and re-arm, then pb[0] pressed → winner=0 (the held bit never wins).
- Foul (macro defined): after pb[1] wins, release pb[1], then press pb[1] and pb[3] → foul=4'b1010; clr → foul=0. With the macro undefined, foul stays 0 throughout.
